// File: rtl/octree_pkg.sv
// octree_pkg: shared walker state encoding, node field layout and octant selection.
package octree_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DECODE, RESP} state_t;
    localparam int MAT_W = 8;
    function automatic int leaf_bit(input int data_width);
        return data_width - 1;
    endfunction
    // sh picks the coordinate bit for the current depth, MSB first
    function automatic logic [2:0] octant(input logic [31:0] x, y, z, input logic [4:0] sh);
        return {x[sh], y[sh], z[sh]};
    endfunction
endpackage

// File: rtl/octree_node_decode.sv
// octree_node_decode: classifies a fetched node and computes the next child address.
module octree_node_decode
    import octree_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int COORD_WIDTH = 8,
    parameter int MEM_DEPTH = 38,
    parameter int DEPTH_W = $clog2(COORD_WIDTH + 1)
) (
    input  logic [DATA_WIDTH-1:0]    mem_dout,
    input  logic [DEPTH_W-1:0]       depth,
    input  logic [COORD_WIDTH-1:0]   x,
    input  logic [COORD_WIDTH-1:0]   y,
    input  logic [COORD_WIDTH-1:0]   z,
    output logic                     is_leaf,
    output logic [MAT_W-1:0]         material,
    output logic [ADDRESS_WIDTH-1:0] child_addr,
    output logic                     error
);
    localparam int LB = leaf_bit(DATA_WIDTH);
    logic [4:0] sh;
    assign sh = 5'(COORD_WIDTH - 1 - int'(depth));
    assign is_leaf = mem_dout[LB];
    assign material = is_leaf ? mem_dout[MAT_W-1:0] : '0;
    assign child_addr = {1'b0, mem_dout[ADDRESS_WIDTH-2:0]}
                      + ADDRESS_WIDTH'(octant(32'(x), 32'(y), 32'(z), sh));
    assign error = !is_leaf && (depth == DEPTH_W'(COORD_WIDTH)
                             || child_addr >= ADDRESS_WIDTH'(MEM_DEPTH));
endmodule

// File: rtl/octree_walker.sv
// octree_walker: walks a ROM-resident octree from the root to the leaf containing a point.
module octree_walker
    import octree_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int COORD_WIDTH = 8,
    parameter int MEM_DEPTH = 38
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [COORD_WIDTH-1:0]           req_x,
    input  logic [COORD_WIDTH-1:0]           req_y,
    input  logic [COORD_WIDTH-1:0]           req_z,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [7:0]                       rsp_material,
    output logic [$clog2(COORD_WIDTH+1)-1:0] rsp_depth,
    output logic                             rsp_error,
    output logic                             mem_ren,
    output logic [ADDRESS_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]            mem_dout
);
    localparam int DEPTH_W = $clog2(COORD_WIDTH + 1);
    state_t state, state_d;
    logic [COORD_WIDTH-1:0] x_q, y_q, z_q;
    logic [ADDRESS_WIDTH-1:0] addr_q, child;
    logic [DEPTH_W-1:0] depth_q;
    logic [MAT_W-1:0] mat_q, dec_mat;
    logic err_q, is_leaf, dec_err;

    octree_node_decode #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .COORD_WIDTH(COORD_WIDTH),
        .MEM_DEPTH(MEM_DEPTH),
        .DEPTH_W(DEPTH_W)
    ) u_decode (
        .mem_dout(mem_dout),
        .depth(depth_q),
        .x(x_q),
        .y(y_q),
        .z(z_q),
        .is_leaf(is_leaf),
        .material(dec_mat),
        .child_addr(child),
        .error(dec_err)
    );

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_d;

    // outputs are gated by rst so they read idle while reset is held
    always_comb begin
        state_d = state;
        case (state)
            IDLE:   state_d = req_valid ? ISSUE : IDLE;
            ISSUE:  state_d = DECODE;
            DECODE: state_d = (is_leaf || dec_err) ? RESP : ISSUE;
            RESP:   state_d = rsp_ready ? IDLE : RESP;
        endcase
        req_ready = !rst && state == IDLE;
        mem_ren = !rst && state == ISSUE;
        rsp_valid = !rst && state == RESP;
        mem_addr = mem_ren ? addr_q : '0;
        rsp_material = rsp_valid ? mat_q : '0;
        rsp_depth = rsp_valid ? depth_q : '0;
        rsp_error = rsp_valid && err_q;
    end

    // depth_q is left untouched on a terminating decode, so it doubles as rsp_depth
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            addr_q <= '0;
            depth_q <= '0;
            mat_q <= '0;
            err_q <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            x_q <= req_x;
            y_q <= req_y;
            z_q <= req_z;
            addr_q <= '0;
            depth_q <= '0;
        end else if (state == DECODE) begin
            if (is_leaf || dec_err) begin
                mat_q <= dec_mat;
                err_q <= dec_err;
            end else begin
                addr_q <= child;
                depth_q <= depth_q + DEPTH_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_octree_walker.sv
// tb_octree_walker: directed vector table plus hand sequences for stall, reset and depth limit.
module tb_octree_walker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_error, mem_ren;
    logic [7:0] req_x, req_y, req_z, rsp_material;
    logic [3:0] rsp_depth;
    logic [31:0] mem_addr, mem_dout;
    logic [31:0] mem [0:63];

    octree_walker dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_material(rsp_material), .rsp_depth(rsp_depth), .rsp_error(rsp_error),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    always @(posedge clk)
        if (mem_ren) mem_dout <= mem[mem_addr[5:0]];

    typedef struct {
        logic [31:0] root;
        logic [7:0]  x, y, z, mat;
        logic [3:0]  dep;
        logic        err;
        int          lat;
    } vec_t;
    vec_t v [9];

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic walk(input logic [7:0] x, y, z, output int lat, output int nren, output logic [31:0] a0);
        int n;
        lat = -1;
        nren = 0;
        a0 = '1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        req_x = x; req_y = y; req_z = z;
        req_valid = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (mem_ren) begin
                if (nren == 0) a0 = mem_addr;
                nren++;
            end
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat, nren;
    logic [31:0] a0;
    bit seen;

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_x = '0; req_y = '0; req_z = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 32'h1;
        for (int o = 0; o < 8; o++) mem[1+o] = 32'h80000010 + o;
        mem[37] = 32'h80000099;
        v[0] = '{32'h1,        8'h80, 8'h00, 8'h80, 8'h15, 4'd1, 1'b0, 5};
        v[1] = '{32'h1,        8'h00, 8'h00, 8'h00, 8'h10, 4'd1, 1'b0, 5};
        v[2] = '{32'h1,        8'hFF, 8'hFF, 8'hFF, 8'h17, 4'd1, 1'b0, 5};
        v[3] = '{32'h1,        8'h7F, 8'h80, 8'h00, 8'h12, 4'd1, 1'b0, 5};
        v[4] = '{32'h1,        8'h00, 8'h00, 8'hC0, 8'h11, 4'd1, 1'b0, 5};
        v[5] = '{32'h80000042, 8'h12, 8'h34, 8'h56, 8'h42, 4'd0, 1'b0, 3};
        v[6] = '{32'h30,       8'h80, 8'h00, 8'h80, 8'h00, 4'd0, 1'b1, 3};
        v[7] = '{32'h1E,       8'hFF, 8'hFF, 8'hFF, 8'h99, 4'd1, 1'b0, 5};
        v[8] = '{32'h1F,       8'hFF, 8'hFF, 8'hFF, 8'h00, 4'd0, 1'b1, 3};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_material", rsp_material, 0);
        chk("rst_depth", rsp_depth, 0);
        chk("rst_error", rsp_error, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1);

        for (int i = 0; i < 9; i++) begin
            mem[0] = v[i].root;
            walk(v[i].x, v[i].y, v[i].z, lat, nren, a0);
            chk($sformatf("v%0d_latency", i), lat, v[i].lat);
            chk($sformatf("v%0d_material", i), rsp_material, v[i].mat);
            chk($sformatf("v%0d_depth", i), rsp_depth, v[i].dep);
            chk($sformatf("v%0d_error", i), rsp_error, v[i].err);
            chk($sformatf("v%0d_ren_pulses", i), nren, v[i].dep + 1);
            chk($sformatf("v%0d_first_addr", i), a0, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle_after", i), req_ready, 1);
        end

        // backpressure, with req_valid held high and coords changed mid-walk
        mem[0] = 32'h1;
        req_x = 8'h80; req_y = 8'h00; req_z = 8'h80;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            req_x = 8'h00; req_z = 8'h00;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        req_valid = 1'b0;
        chk("stall_latency", lat, 5);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_material", rsp_material, 8'h15);
            chk("stall_depth", rsp_depth, 1);
            chk("stall_error", rsp_error, 0);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_mem_ren", mem_ren, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", rsp_valid, 0);
        chk("stall_release_ready", req_ready, 1);

        // reset in cycle 3 abandons the walk
        req_x = 8'h80; req_y = 8'h00; req_z = 8'h80;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_mem_ren", mem_ren, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_ready", req_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("midrst_no_rsp", seen, 0);
        walk(8'h00, 8'h00, 8'h00, lat, nren, a0);
        chk("post_rst_latency", lat, 5);
        chk("post_rst_material", rsp_material, 8'h10);
        @(posedge clk); #1;

        // chain of internal nodes running out of depth
        for (int k = 0; k <= 8; k++) mem[k] = k + 1;
        walk(8'h00, 8'h00, 8'h00, lat, nren, a0);
        chk("chain_latency", lat, 19);
        chk("chain_error", rsp_error, 1);
        chk("chain_depth", rsp_depth, 8);
        chk("chain_material", rsp_material, 0);
        chk("chain_ren_pulses", nren, 9);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
